logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one 16-bit bitwise logic unit (AND/OR/XOR/ANDN, built on the *_16bit gate arrays)
//  between two requesters, e.g. the execute-stage ALU path and the compare/flag path.
//  Round-robin arbitration picks one request per cycle. The block computes the result and
//  holds it in a single-entry output register until the consumer takes it.
//  It sits between the decode-side requesters and the writeback mux in the datapath.
// PARAMETERS
//  WIDTH    16   operand/result width
//  OPW      2    opcode width (fixed encoding below)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous reset, ACTIVE-LOW (0 = reset)
//  req0_valid   in   1      requester 0 has an operation
//  req0_ready   out  1      requester 0 accepted this cycle (valid & ready = transfer)
//  req0_op      in   OPW    requester 0 opcode
//  req0_a       in   WIDTH  requester 0 operand A
//  req0_b       in   WIDTH  requester 0 operand B
//  req1_valid   in   1      requester 1 has an operation
//  req1_ready   out  1      requester 1 accepted this cycle
//  req1_op      in   OPW    requester 1 opcode
//  req1_a       in   WIDTH  requester 1 operand A
//  req1_b       in   WIDTH  requester 1 operand B
//  rsp_valid    out  1      result register holds a valid result
//  rsp_ready    in   1      consumer takes the result this cycle
//  rsp_id       out  1      which requester produced rsp_data (0/1)
//  rsp_data     out  WIDTH  registered result
// BEHAVIOUR
//  Opcodes: 00 = a&b, 01 = a|b, 10 = a^b, 11 = a&~b (ANDN). Results are pure bitwise, no flags.
//  Reset (rst=0, async): rsp_valid=0, rsp_data=0, rsp_id=0, prio=0.
//   - A held result is discarded.
//   - Both readys are 0 while rst=0.
//  slot_free = !rsp_valid | rsp_ready. The output register can accept a new result this cycle.
//  Arbitration (combinational, same cycle):
//   - Only one valid: that requester wins.
//   - Both valid: requester == prio wins.
//   - reqN_ready = slot_free & (winner == N). At most one ready is high per cycle.
//   - No ready is asserted without the matching valid.
//  On transfer (rising edge):
//   - rsp_data <= op(winner a,b); rsp_id <= winner; rsp_valid <= 1.
//   - prio <= ~winner. prio changes only on a transfer.
//  Latency: result visible 1 cycle after the transfer edge. Throughput: 1 op/cycle while rsp_ready=1.
//  Drain without a new transfer: rsp_valid <= 0. rsp_data and rsp_id keep their old values.
//  Simultaneous drain and accept: the new result replaces the old one in the same edge (no bubble).
//  Backpressure: rsp_valid=1 & rsp_ready=0 -> both readys 0.
//   - rsp_data and rsp_id are stable.
//   - prio does not change.
//  Requesters must hold op/a/b stable while valid & !ready. Valid must not depend on ready.
//  rsp_data changes only on a transfer edge or reset.
// TESTING
//  1. Reset: drive rst=0 mid-stream with rsp_valid=1.
//     -> rsp_valid, rsp_data, rsp_id are 0 immediately (before the next edge); readys are 0.
//  2. Single requester: req0 op=00 a=16'hF0F0 b=16'h3C3C.
//     -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=16'h3030.
//  3. Opcode sweep on req1 with a=16'hAAAA b=16'h0FF0:
//     -> OR 16'hAFFA, XOR 16'hA55A, ANDN 16'hA00A, each with rsp_id=1.
//  4. Both valid every cycle, rsp_ready=1 held:
//     -> grants alternate 0,1,0,1 starting with 0 after reset; one rsp per cycle.
//  5. Backpressure: rsp_ready=0 with a result held and both valid.
//     -> readys 0, rsp_data stable for 5 cycles.
//     -> Raise rsp_ready: same-cycle accept of the prio requester, no bubble.
//  6. Fairness: req0 valid continuously, req1 pulses valid.
//     -> req1 is granted on the first cycle after req0 wins with req1 valid; it never waits more than 1 grant.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared 16-bit bitwise logic unit.
// The result sits in a single-entry output register until the consumer takes it.
module logic_unit_arbiter #(
   parameter int WIDTH = 16,
   parameter int OPW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data
);

   logic             prio;
   logic             slot_free;
   logic             winner;
   logic             grant_any;
   logic [OPW-1:0]   win_op;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic [WIDTH-1:0] lu_result;

   // With a single valid requester the winner is simply that requester;
   // prio only breaks ties.
   always_comb begin
      slot_free  = !rsp_valid || rsp_ready;
      winner     = (req0_valid && req1_valid) ? prio : req1_valid;
      grant_any  = rst && slot_free && (req0_valid || req1_valid);
      req0_ready = grant_any && !winner;
      req1_ready = grant_any && winner;
   end

   always_comb begin
      win_op = winner ? req1_op : req0_op;
      win_a  = winner ? req1_a  : req0_a;
      win_b  = winner ? req1_b  : req0_b;
   end

   always_comb begin
      lu_result = '0;
      case (win_op)
         2'd0:    lu_result = win_a & win_b;
         2'd1:    lu_result = win_a | win_b;
         2'd2:    lu_result = win_a ^ win_b;
         default: lu_result = win_a & ~win_b;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= 1'b0;
         prio      <= 1'b0;
      end else if (grant_any) begin
         rsp_valid <= 1'b1;
         rsp_data  <= lu_result;
         rsp_id    <= winner;
         prio      <= !winner;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of the arbiter.
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [1:0]  req0_op;
   logic [15:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [1:0]  req1_op;
   logic [15:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_data;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic        m_valid, m_id, m_prio;
   logic [15:0] m_data;
   int          last_w;

   logic_unit_arbiter #(.WIDTH(16), .OPW(2)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return a & ~b;
      endcase
   endfunction

   // -1 = nobody is granted this cycle
   function automatic int exp_winner();
      if (!rst) return -1;
      if (m_valid && !rsp_ready) return -1;
      if (req0_valid && req1_valid) return int'(m_prio);
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = 16'h0; m_id = 1'b0; m_prio = 1'b0;
   endtask

   // advance one clock; model follows the transfer rules at the edge
   task automatic tick();
      int w;
      w = exp_winner();
      @(posedge clk);
      if (rst) begin
         if (w == 0) begin
            m_data = lu_ref(req0_op, req0_a, req0_b); m_id = 1'b0; m_valid = 1'b1; m_prio = 1'b1;
         end else if (w == 1) begin
            m_data = lu_ref(req1_op, req1_a, req1_b); m_id = 1'b1; m_valid = 1'b1; m_prio = 1'b0;
         end else if (rsp_ready) begin
            m_valid = 1'b0;
         end
      end
      last_w = w;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = 2'd0; req0_a = 16'h1234; req0_b = 16'hFFFF;
      req1_op = 2'd1; req1_a = 16'h5678; req1_b = 16'h0000;
      #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", rsp_data); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b want 0", rsp_id); end
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_readys: got %b want 00", {req0_ready, req1_ready}); end
      repeat (2) @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b want 0", rsp_valid); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_op = 2'd0; req0_a = 16'hF0F0; req0_b = 16'h3C3C;
      rsp_ready = 1'b1;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 1'b0;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %b want 0", rsp_id); end
      n_checks++; if (rsp_data !== 16'h3030) begin n_fail++; $display("FAIL single_data: got %h want 3030", rsp_data); end
      tick();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_data !== 16'h3030) begin n_fail++; $display("FAIL drain_data_kept: got %h want 3030", rsp_data); end
   endtask

   task automatic test_opcodes();
      logic [15:0] exp_tab [3] = '{16'hAFFA, 16'hA55A, 16'hA00A};
      for (int i = 0; i < 3; i++) begin
         req1_valid = 1'b1; req1_op = 2'(i + 1); req1_a = 16'hAAAA; req1_b = 16'h0FF0;
         #1;
         n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL op%0d_ready: got %b want 01", i + 1, {req0_ready, req1_ready}); end
         tick();
         n_checks++; if (rsp_data !== exp_tab[i]) begin n_fail++; $display("FAIL op%0d_data: got %h want %h", i + 1, rsp_data, exp_tab[i]); end
         n_checks++; if (rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL op%0d_id: got id=%b v=%b want id=1 v=1", i + 1, rsp_id, rsp_valid); end
      end
      req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] ed;
      rst = 1'b0; #1; rst = 1'b1; model_reset();
      @(negedge clk);
      rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req0_op = 2'($urandom_range(0, 3)); req0_a = 16'($urandom); req0_b = 16'($urandom);
         req1_op = 2'($urandom_range(0, 3)); req1_a = 16'($urandom); req1_b = 16'($urandom);
         ed = (i % 2 == 0) ? lu_ref(req0_op, req0_a, req0_b) : lu_ref(req1_op, req1_a, req1_b);
         #1;
         n_checks++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
         tick();
         n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_data !== ed) begin n_fail++; $display("FAIL b2b_rsp%0d: got v=%b id=%b d=%h want v=1 id=%0d d=%h", i, rsp_valid, rsp_id, rsp_data, i % 2, ed); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] held, ed;
      logic        hid;
      held = m_data; hid = m_id;
      rsp_ready = 1'b0;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_readys: got %b want 00", {req0_ready, req1_ready}); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (rsp_data !== held || rsp_id !== hid || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable%0d: got v=%b id=%b d=%h want v=1 id=%b d=%h", i, rsp_valid, rsp_id, rsp_data, hid, held); end
         n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_readys%0d: got %b want 00", i, {req0_ready, req1_ready}); end
      end
      // last back-to-back grant went to req1, so req0 holds priority
      rsp_ready = 1'b1;
      ed = lu_ref(req0_op, req0_a, req0_b);
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_release_ready: got %b want 10", {req0_ready, req1_ready}); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== ed) begin n_fail++; $display("FAIL bp_release_rsp: got v=%b id=%b d=%h want v=1 id=0 d=%h", rsp_valid, rsp_id, rsp_data, ed); end
   endtask

   task automatic test_reset_midstream();
      rsp_ready = 1'b0;
      tick();
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL midreset_rsp: got v=%b id=%b d=%h want 0 0 0000", rsp_valid, rsp_id, rsp_data); end
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL midreset_readys: got %b want 00", {req0_ready, req1_ready}); end
      @(negedge clk);
      rst = 1'b1; model_reset();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_fairness();
      int waits, max_waits;
      logic [15:0] ed;
      waits = 0; max_waits = 0;
      rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0; last_w = 0;
      for (int i = 0; i < 60; i++) begin
         if (last_w == 0) begin req0_op = 2'($urandom_range(0, 3)); req0_a = 16'($urandom); req0_b = 16'($urandom); end
         if (!req1_valid || last_w == 1) begin
            req1_valid = ($urandom_range(0, 2) == 0);
            req1_op = 2'($urandom_range(0, 3)); req1_a = 16'($urandom); req1_b = 16'($urandom);
         end
         #1;
         n_checks++; if (req0_ready !== (exp_winner() == 0) || req1_ready !== (exp_winner() == 1)) begin n_fail++; $display("FAIL fair_ready%0d: got %b want w=%0d", i, {req0_ready, req1_ready}, exp_winner()); end
         if (req1_valid && req0_ready) waits++;
         if (req1_ready) waits = 0;
         if (waits > max_waits) max_waits = waits;
         tick();
         ed = m_data;
         n_checks++; if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_data !== ed) begin n_fail++; $display("FAIL fair_rsp%0d: got v=%b id=%b d=%h want v=%b id=%b d=%h", i, rsp_valid, rsp_id, rsp_data, m_valid, m_id, ed); end
      end
      n_checks++; if (max_waits > 1) begin n_fail++; $display("FAIL fair_max_wait: got %0d want <=1", max_waits); end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_random();
      int w;
      last_w = -1;
      for (int i = 0; i < 300; i++) begin
         if (!req0_valid || last_w == 0) begin
            req0_valid = ($urandom_range(0, 1) == 1);
            req0_op = 2'($urandom_range(0, 3)); req0_a = 16'($urandom); req0_b = 16'($urandom);
         end
         if (!req1_valid || last_w == 1) begin
            req1_valid = ($urandom_range(0, 1) == 1);
            req1_op = 2'($urandom_range(0, 3)); req1_a = 16'($urandom); req1_b = 16'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         w = exp_winner();
         n_checks++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin n_fail++; $display("FAIL rand_ready%0d: got %b want w=%0d", i, {req0_ready, req1_ready}, w); end
         tick();
         n_checks++; if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_data !== m_data) begin n_fail++; $display("FAIL rand_rsp%0d: got v=%b id=%b d=%h want v=%b id=%b d=%h", i, rsp_valid, rsp_id, rsp_data, m_valid, m_id, m_data); end
      end
   endtask

   initial begin
      model_reset();
      last_w = -1;
      test_reset();
      @(negedge clk);
      test_single();
      test_opcodes();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_fairness();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
